// File: rtl/vram_arbiter.sv
// ============================================================================
//  vram_arbiter : shares a single-port VRAM between scanout and CPU writes.
//  Optional VRAM_ARB_BLANK_ONLY_EN restricts CPU writes to blanking.
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module vram_arbiter #(
   parameter int XBITS   = 10,
   parameter int YBITS   = 10,
   parameter int HACTIVE = 640,
   parameter int VACTIVE = 480,
   parameter int ABITS   = 17,
   parameter int DBITS   = 8
) (
   input  logic             Clk,
   input  logic             ResetN,
   input  logic [XBITS-1:0] PixelCounter,
   input  logic [YBITS-1:0] LineCounter,
   input  logic             WrReq,
   input  logic [ABITS-1:0] WrAddr,
   input  logic [DBITS-1:0] WrData,
   output logic             WrAck,
   output logic             WrOvf,
   output logic [ABITS-1:0] MemAddr,
   output logic             MemWe,
   output logic [DBITS-1:0] MemWData,
   input  logic [DBITS-1:0] MemRData,
   output logic [DBITS-1:0] PixelData,
   output logic             PixelActive
);

   localparam int             C_WORDS = (HACTIVE / 2) * (VACTIVE / 2);
   localparam int             C_PW    = XBITS + YBITS + 2;
   localparam logic [ABITS:0] C_LIMIT = (ABITS + 1)'(C_WORDS);

   logic             w_active;
   logic             w_fetch;
   logic             w_grant;
   logic             w_inrange;
   logic [ABITS-1:0] w_fetch_addr;

   logic             r_fetch_d1;
   logic             r_fetch_d2;
   logic             r_active_d1;
   logic             r_active_d2;

   assign w_active = (32'(PixelCounter) < 32'(HACTIVE)) &&
                     (32'(LineCounter)  < 32'(VACTIVE));
   assign w_fetch  = w_active && !PixelCounter[0];

   // Each VRAM word covers a 2x2 block, so both coordinates are halved.
   assign w_fetch_addr = ABITS'(C_PW'(LineCounter >> 1) * C_PW'(HACTIVE / 2)
                                + C_PW'(PixelCounter >> 1));

   assign w_inrange = ({1'b0, WrAddr} < C_LIMIT);

`ifdef VRAM_ARB_BLANK_ONLY_EN
   assign w_grant = WrReq && !WrAck && !w_active;
`else
   assign w_grant = WrReq && !WrAck && !w_fetch;
`endif

   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         MemAddr     <= '0;
         MemWe       <= 1'b0;
         MemWData    <= '0;
         WrAck       <= 1'b0;
         WrOvf       <= 1'b0;
         PixelData   <= '0;
         PixelActive <= 1'b0;
         r_fetch_d1  <= 1'b0;
         r_fetch_d2  <= 1'b0;
         r_active_d1 <= 1'b0;
         r_active_d2 <= 1'b0;
      end else begin
         MemWe <= 1'b0;
         WrAck <= 1'b0;

         if (w_fetch) begin
            MemAddr <= w_fetch_addr;
         end else if (w_grant) begin
            MemAddr  <= WrAddr;
            MemWData <= WrData;
            WrAck    <= 1'b1;
            if (w_inrange) begin
               MemWe <= 1'b1;
            end else begin
               WrOvf <= 1'b1;
            end
         end

         r_fetch_d1  <= w_fetch;
         r_fetch_d2  <= r_fetch_d1;
         r_active_d1 <= w_active;
         r_active_d2 <= r_active_d1;

         // Odd pixels reuse the word fetched for the preceding even pixel.
         if (r_fetch_d2) begin
            PixelData <= MemRData;
         end else if (!r_active_d2) begin
            PixelData <= '0;
         end
         PixelActive <= r_active_d2;
      end
   end

endmodule

`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Shares a single-port synchronous video RAM between display scanout and a CPU-side write port, scheduling accesses from the free-running pixel/line counter position. Sits between the `vcounter` instance, the frame buffer RAM and the pixel output stage. Scanout owns every even active pixel slot and is never delayed. CPU writes are granted in all remaining slots. The frame buffer is half resolution in both axes, so each word is shown as a 2×2 display block.

## Interface
Parameters:
- XBITS, 10, width of PixelCounter input
- YBITS, 10, width of LineCounter input
- HACTIVE, 640, visible pixels per line (even)
- VACTIVE, 480, visible lines per frame (even)
- ABITS, 17, VRAM address width; must hold (HACTIVE/2)*(VACTIVE/2)-1
- DBITS, 8, pixel/word width

Ports:
- Clk  in  1  pixel clock, all logic on rising edge
- ResetN  in  1  synchronous, active-low reset
- PixelCounter  in  XBITS  current pixel x from vcounter
- LineCounter  in  YBITS  current line y from vcounter
- WrReq  in  1  CPU write request, level
- WrAddr  in  ABITS  CPU word address, stable while WrReq high
- WrData  in  DBITS  CPU write data, stable while WrReq high
- WrAck  out  1  one-cycle pulse: write performed or dropped
- WrOvf  out  1  sticky: an out-of-range write was dropped
- MemAddr  out  ABITS  registered VRAM address
- MemWe  out  1  registered VRAM write enable
- MemWData  out  DBITS  registered VRAM write data
- MemRData  in  DBITS  VRAM read data, valid one cycle after MemAddr is presented
- PixelData  out  DBITS  scanout pixel value, 0 when blanked
- PixelActive  out  1  PixelData is a visible pixel

## Operation
- Active: x < HACTIVE and y < VACTIVE. Fetch slot: active and x even.
- Fetch address: (y>>1)*(HACTIVE/2) + (x>>1), computed modulo 2^ABITS. Incremental address registers are allowed if they give identical results.
- Slot decision, per cycle t with counter (x,y):
  - FETCH: in a fetch slot, register MemAddr = fetch address, MemWe = 0.
  - WRITE: not a fetch slot, WrReq = 1, and WrAck not high in cycle t. Register MemAddr = WrAddr, MemWData = WrData. MemWe = 1 only if WrAddr < (HACTIVE/2)*(VACTIVE/2). Otherwise MemWe = 0 and WrOvf is set. WrAck pulses in cycle t+1 in both cases.
  - IDLE: otherwise. MemWe = 0, MemAddr holds its previous value.
- Turnaround: no grant in a cycle where WrAck is high. Maximum CPU throughput is one write per 2 cycles.
- Requester holds WrReq/WrAddr/WrData until it sees WrAck. It may keep WrReq high for back-to-back writes, changing WrAddr/WrData in the ack cycle.
- Counter wrap (x→0, y→0) needs no special handling; the next fetch slot is recomputed from the inputs.

## Timing
- Reset (ResetN = 0 at an edge): MemAddr = 0, MemWe = 0, MemWData = 0, WrAck = 0, WrOvf = 0, PixelData = 0, PixelActive = 0.
- Reset mid-write drops any pending ack. The requester must re-issue. A write registered before the reset edge is not retracted.
- Scanout latency is 3 cycles. For even active x seen in cycle t:
  - MemAddr is valid in t+1.
  - MemRData is valid in t+2.
  - PixelData is valid in t+3 and held through t+4, covering pixels x and x+1.
- For non-active (x,y) seen in cycle t, PixelData = 0 and PixelActive = 0 in t+3.
- PixelActive in t+3 equals active(x,y) at t. Downstream sync generation must be delayed by 3 cycles.
- A CPU write granted in cycle t reaches VRAM in t+1. A fetch of the same address issued at t+1 or later returns the new data.

## Configuration
- VRAM_ARB_BLANK_ONLY_EN defined: WRITE grants occur only when not active (x ≥ HACTIVE or y ≥ VACTIVE). Odd active slots are IDLE. This gives tear-free updates.
- Undefined: grants also occur in odd active slots, as described above.

## Test plan
- Reset: hold ResetN = 0 for 3 cycles with WrReq = 1 -> all outputs 0, no MemWe; first grant is in the first eligible slot after release.
- Scanout: preload VRAM[k] = k, HACTIVE = 8, VACTIVE = 4, run one frame -> on line 0 and line 1, PixelData sequence from t+3 is 0,0,1,1,2,2,3,3; lines 2 and 3 give 4,4,5,5,…; PixelActive aligned.
- Active write: WrReq at x = 2 (even), y = 0, WrAddr = 5, WrData = 0xA5 -> grant at x = 3, MemWe = 1 in the x = 4 cycle, WrAck one pulse; the next frame shows 0xA5 at display pixels (2..3, 2..3) of the 8×4 test config.
- Back-to-back: WrReq held for 4 writes during blanking -> WrAck at cycles 1, 3, 5, 7 relative to first grant; exactly 4 MemWe pulses.
- Overflow: WrAddr = (HACTIVE/2)*(VACTIVE/2) -> WrAck pulses, MemWe stays 0, WrOvf = 1 until reset.
- Macro: with VRAM_ARB_BLANK_ONLY_EN defined, WrReq during active video -> no MemWe until x = HACTIVE; WrAck follows one cycle after the grant.
